// File: rtl/alu_issue_sequencer_pkg.sv
// Shared op encodings, flag bit positions and sequencer states.
// Imported by the sequencer and its latency lookup.
package alu_issue_sequencer_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_MUL = 3'd4;
  localparam logic [2:0] OP_DIV = 3'd5;

  localparam int FLG_C = 3;
  localparam int FLG_V = 2;
  localparam int FLG_N = 1;
  localparam int FLG_Z = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // Flags for non-arithmetic results: the ALU's N/Z follow the adder, not the muxed result.
  function automatic logic [3:0] result_flags(input logic [15:0] r);
    logic [3:0] f;
    f        = '0;
    f[FLG_N] = r[15];
    f[FLG_Z] = (r == 16'h0000);
    return f;
  endfunction

endpackage

// File: rtl/alu_issue_sequencer_op_latency.sv
// Op -> settle cycle count lookup; purely combinational, no backpressure.
module alu_op_latency
  import alu_issue_sequencer_pkg::*;
#(
  parameter int ADD_CYCLES   = 1,
  parameter int LOGIC_CYCLES = 1,
  parameter int MUL_CYCLES   = 4,
  parameter int DIV_CYCLES   = 8,
  parameter int CNT_W        = 4
) (
  input  logic [2:0]       op,
  output logic [CNT_W-1:0] cycles
);

  always_comb begin
    cycles = CNT_W'(1);
    case (op)
      OP_ADD, OP_SUB: cycles = CNT_W'(ADD_CYCLES);
      OP_AND, OP_OR:  cycles = CNT_W'(LOGIC_CYCLES);
      OP_MUL:         cycles = CNT_W'(MUL_CYCLES);
      OP_DIV:         cycles = CNT_W'(DIV_CYCLES);
      default:        cycles = CNT_W'(1);
    endcase
  end

endmodule

// File: rtl/alu_issue_sequencer.sv
// Issue/capture stage around the ALU: result N(op) cycles after accept (divide-by-zero/illegal skip settle);
// one op in flight, in_ready only in IDLE, result held until out_ready.
module alu_issue_sequencer
  import alu_issue_sequencer_pkg::*;
#(
  parameter int ADD_CYCLES   = 1,
  parameter int LOGIC_CYCLES = 1,
  parameter int MUL_CYCLES   = 4,
  parameter int DIV_CYCLES   = 8,
  parameter int TAG_W        = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [15:0]      alu_a,
  output logic [15:0]      alu_b,
  output logic             alu_sub,
  output logic [2:0]       alu_op_select,
  input  logic [15:0]      alu_result,
  input  logic             alu_cout,
  input  logic             alu_overflow,
  input  logic             alu_NO,
  input  logic             alu_ZO,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_result,
  output logic [3:0]       out_flags,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_dz,
  output logic             out_illegal
);

  localparam int MAX_AL = (ADD_CYCLES > LOGIC_CYCLES) ? ADD_CYCLES : LOGIC_CYCLES;
  localparam int MAX_MD = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int MAX_C  = (MAX_AL > MAX_MD) ? MAX_AL : MAX_MD;
  localparam int CNT_W  = $clog2(MAX_C) + 1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] n_cycles;
  logic             accept, capture, done;
  logic             is_dz, is_ill;
  logic [3:0]       cap_flags;

  alu_op_latency #(
    .ADD_CYCLES  (ADD_CYCLES),
    .LOGIC_CYCLES(LOGIC_CYCLES),
    .MUL_CYCLES  (MUL_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_op_latency (
    .op    (in_op),
    .cycles(n_cycles)
  );

  assign is_ill    = (in_op > OP_DIV);
  assign is_dz     = (in_op == OP_DIV) && (in_b == 16'h0000);
  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = (is_ill || is_dz) ? HOLD : SETTLE;
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cap_flags = result_flags(alu_result);
    if (alu_op_select == OP_ADD || alu_op_select == OP_SUB) begin
      cap_flags[FLG_C] = alu_cout;
      cap_flags[FLG_V] = alu_overflow;
      cap_flags[FLG_N] = alu_NO;
      cap_flags[FLG_Z] = alu_ZO;
    end
  end

  // alu_* only change on accept so the ALU inputs stay quiet outside an issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a         <= '0;
      alu_b         <= '0;
      alu_sub       <= 1'b0;
      alu_op_select <= '0;
      cnt           <= '0;
      out_result    <= '0;
      out_flags     <= '0;
      out_tag       <= '0;
      out_dz        <= 1'b0;
      out_illegal   <= 1'b0;
    end else begin
      if (accept) begin
        alu_a         <= in_a;
        alu_b         <= in_b;
        alu_sub       <= (in_op == OP_SUB);
        alu_op_select <= in_op;
        out_tag       <= in_tag;
        cnt           <= n_cycles - CNT_W'(1);
        if (is_ill) begin
          out_result  <= 16'h0000;
          out_flags   <= 4'h0;
          out_illegal <= 1'b1;
        end else if (is_dz) begin
          out_result <= 16'hFFFF;
          out_flags  <= 4'h0;
          out_dz     <= 1'b1;
        end
      end
      if (capture) begin
        out_result <= alu_result;
        out_flags  <= cap_flags;
      end else if (state == SETTLE) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (done) begin
        out_dz      <= 1'b0;
        out_illegal <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Bench for alu_issue_sequencer with a behavioural ALU stand-in and an arithmetic reference model.
module tb_alu_issue_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic [15:0] in_a = '0, in_b = '0;
  logic [3:0]  in_tag = '0;
  logic [15:0] alu_a, alu_b;
  logic        alu_sub;
  logic [2:0]  alu_op_select;
  logic [15:0] alu_result;
  logic        alu_cout, alu_overflow, alu_NO, alu_ZO;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_result;
  logic [3:0]  out_flags;
  logic [3:0]  out_tag;
  logic        out_dz, out_illegal;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_issue_sequencer #(
    .ADD_CYCLES(1), .LOGIC_CYCLES(1), .MUL_CYCLES(4), .DIV_CYCLES(8), .TAG_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sub(alu_sub), .alu_op_select(alu_op_select),
    .alu_result(alu_result), .alu_cout(alu_cout), .alu_overflow(alu_overflow),
    .alu_NO(alu_NO), .alu_ZO(alu_ZO),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags),
    .out_tag(out_tag), .out_dz(out_dz), .out_illegal(out_illegal)
  );

  // ALU stand-in: flags always come from the adder path, result is muxed by op.
  always_comb begin
    logic [16:0] s;
    logic [15:0] bb;
    bb           = alu_sub ? ~alu_b : alu_b;
    s            = {1'b0, alu_a} + {1'b0, bb} + {16'h0000, alu_sub};
    alu_cout     = s[16];
    alu_overflow = (alu_a[15] == bb[15]) && (s[15] != alu_a[15]);
    alu_NO       = s[15];
    alu_ZO       = (s[15:0] == 16'h0000);
    case (alu_op_select)
      3'd0, 3'd1: alu_result = s[15:0];
      3'd2:       alu_result = alu_a & alu_b;
      3'd3:       alu_result = alu_a | alu_b;
      3'd4:       alu_result = alu_a * alu_b;
      3'd5:       alu_result = (alu_b != 16'h0000) ? alu_a / alu_b : 16'h0000;
      default:    alu_result = 16'hA5A5;
    endcase
  end

  function automatic int ref_lat(input logic [2:0] op, input logic [15:0] b);
    if (op > 3'd5 || (op == 3'd5 && b == 16'h0000)) return 0;
    case (op)
      3'd4:    return 4;
      3'd5:    return 8;
      default: return 1;
    endcase
  endfunction

  function automatic logic [15:0] ref_res(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int ia, ib;
    ia = int'(a);
    ib = int'(b);
    case (op)
      3'd0:    return 16'(ia + ib);
      3'd1:    return 16'(ia - ib);
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return 16'(ia * ib);
      3'd5:    return (ib == 0) ? 16'hFFFF : 16'(ia / ib);
      default: return 16'h0000;
    endcase
  endfunction

  // Flags as {C,V,N,Z}; arithmetic ops judged by exact integer range, others by the result alone.
  function automatic logic [3:0] ref_flags(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    int sa, sb, sr;
    logic c, v;
    r = ref_res(op, a, b);
    if (op > 3'd5 || (op == 3'd5 && b == 16'h0000)) return 4'h0;
    if (op > 3'd1) return {2'b00, r[15], r == 16'h0000};
    sa = int'($signed(a));
    sb = int'($signed(b));
    sr = (op == 3'd0) ? sa + sb : sa - sb;
    v  = (sr > 32767) || (sr < -32768);
    c  = (op == 3'd0) ? ((int'(a) + int'(b)) > 65535) : (a >= b);
    return {c, v, r[15], r == 16'h0000};
  endfunction

  // Issues one op, measures cycles from the accepting edge to out_valid, then stalls `hold` cycles
  // while offering a conflicting op, and finally completes the handshake.
  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] tag, input int hold,
                        output int lat, output logic [15:0] res, output logic [3:0] flg,
                        output logic [3:0] tg, output logic dz, output logic ill, output logic sub,
                        output bit stable, output bit after_ok);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin @(posedge clk); #1; w++; end
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    if (!out_valid) lat = -1;
    res = out_result; flg = out_flags; tg = out_tag; dz = out_dz; ill = out_illegal; sub = alu_sub;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; in_op = 3'd0; in_a = ~a; in_b = 16'h0001; in_tag = ~tag;
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_result !== res || out_flags !== flg || out_tag !== tg ||
          out_dz !== dz || out_illegal !== ill || in_ready !== 1'b0 ||
          alu_a !== a || alu_b !== b || alu_op_select !== op) stable = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    after_ok = (out_valid === 1'b0) && (out_dz === 1'b0) && (out_illegal === 1'b0) &&
               (in_ready === 1'b1) && (alu_a === a);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b00) begin
      errors++; $display("FAIL reset_hs got in_ready=%b out_valid=%b need 0 0", in_ready, out_valid);
    end
    checks++;
    if ({alu_a, alu_b, alu_sub, alu_op_select, out_result, out_flags, out_tag, out_dz, out_illegal} !== '0) begin
      errors++; $display("FAIL reset_regs got a=%h b=%h res=%h flags=%h tag=%h need all zero",
                         alu_a, alu_b, out_result, out_flags, out_tag);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release in_ready got %b need 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [2:0]  v_op  [5] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd7};
    logic [15:0] v_a   [5] = '{16'h7FFF, 16'd5, 16'd300, 16'd100, 16'h1234};
    logic [15:0] v_b   [5] = '{16'h0001, 16'd5, 16'd200, 16'd0, 16'h5678};
    logic [15:0] v_res [5] = '{16'h8000, 16'h0000, 16'hEA60, 16'hFFFF, 16'h0000};
    logic [3:0]  v_flg [5] = '{4'b0110, 4'b1001, 4'b0010, 4'b0000, 4'b0000};
    int          v_lat [5] = '{1, 1, 4, 0, 0};
    int lat; logic [15:0] res; logic [3:0] flg, tg; logic dz, ill, sub; bit stable, after_ok;
    for (int i = 0; i < 5; i++) begin
      run_op(v_op[i], v_a[i], v_b[i], 4'(i + 3), 0, lat, res, flg, tg, dz, ill, sub, stable, after_ok);
      checks++;
      if (lat !== v_lat[i]) begin errors++; $display("FAIL dir%0d_latency got %0d need %0d", i, lat, v_lat[i]); end
      checks++;
      if (res !== v_res[i]) begin errors++; $display("FAIL dir%0d_result got %h need %h", i, res, v_res[i]); end
      checks++;
      if (flg !== v_flg[i]) begin errors++; $display("FAIL dir%0d_flags got %b need %b", i, flg, v_flg[i]); end
      checks++;
      if ({dz, ill} !== {v_op[i] == 3'd5, v_op[i] == 3'd7}) begin
        errors++; $display("FAIL dir%0d_exc got dz=%b ill=%b", i, dz, ill);
      end
      checks++;
      if (sub !== (v_op[i] == 3'd1)) begin errors++; $display("FAIL dir%0d_alu_sub got %b", i, sub); end
      checks++;
      if (tg !== 4'(i + 3)) begin errors++; $display("FAIL dir%0d_tag got %h need %h", i, tg, 4'(i + 3)); end
      checks++;
      if (after_ok !== 1'b1) begin errors++; $display("FAIL dir%0d_release got 0 need 1", i); end
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [15:0] res; logic [3:0] flg, tg; logic dz, ill, sub; bit stable, after_ok;
    run_op(3'd5, 16'd1000, 16'd7, 4'hC, 5, lat, res, flg, tg, dz, ill, sub, stable, after_ok);
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL bp_latency got %0d need 8", lat); end
    checks++;
    if (res !== 16'd142) begin errors++; $display("FAIL bp_result got %h need %h", res, 16'd142); end
    checks++;
    if (stable !== 1'b1) begin errors++; $display("FAIL bp_stable got 0 need 1"); end
    checks++;
    if (after_ok !== 1'b1) begin errors++; $display("FAIL bp_release got 0 need 1"); end
  endtask

  task automatic test_mid_reset();
    bit quiet;
    in_valid = 1'b1; in_op = 3'd5; in_a = 16'd500; in_b = 16'd3; in_tag = 4'h6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if ({in_ready, out_valid} !== 2'b00) begin
      errors++; $display("FAIL midrst_busy got in_ready=%b out_valid=%b need 0 0", in_ready, out_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, alu_a, out_tag} !== '0) begin
      errors++; $display("FAIL midrst_cleared got out_valid=%b in_ready=%b alu_a=%h tag=%h need zero",
                         out_valid, in_ready, alu_a, out_tag);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b need 1", in_ready); end
    quiet = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (out_valid !== 1'b0) quiet = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if (quiet !== 1'b1) begin errors++; $display("FAIL midrst_no_output got out_valid pulse need none"); end
  endtask

  task automatic test_random();
    int lat; logic [15:0] res; logic [3:0] flg, tg; logic dz, ill, sub; bit stable, after_ok;
    logic [2:0] op; logic [15:0] a, b; logic [3:0] tag;
    for (int n = 0; n < 30; n++) begin
      op  = 3'($urandom_range(0, 7));
      a   = 16'($urandom);
      b   = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      if ($urandom_range(0, 4) == 0) a = b;
      tag = 4'($urandom);
      run_op(op, a, b, tag, int'($urandom_range(0, 3)), lat, res, flg, tg, dz, ill, sub, stable, after_ok);
      checks++;
      if (lat !== ref_lat(op, b)) begin
        errors++; $display("FAIL rnd%0d_latency op=%0d got %0d need %0d", n, op, lat, ref_lat(op, b));
      end
      checks++;
      if (res !== ref_res(op, a, b)) begin
        errors++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h got %h need %h", n, op, a, b, res, ref_res(op, a, b));
      end
      checks++;
      if (flg !== ref_flags(op, a, b)) begin
        errors++; $display("FAIL rnd%0d_flags op=%0d a=%h b=%h got %b need %b", n, op, a, b, flg, ref_flags(op, a, b));
      end
      checks++;
      if ({dz, ill} !== {op == 3'd5 && b == 16'h0000, op > 3'd5}) begin
        errors++; $display("FAIL rnd%0d_exc op=%0d got dz=%b ill=%b", n, op, dz, ill);
      end
      checks++;
      if (tg !== tag) begin errors++; $display("FAIL rnd%0d_tag got %h need %h", n, tg, tag); end
      checks++;
      if (stable !== 1'b1) begin errors++; $display("FAIL rnd%0d_stable got 0 need 1", n); end
      checks++;
      if (after_ok !== 1'b1) begin errors++; $display("FAIL rnd%0d_release got 0 need 1", n); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
